ram_uart_dump: RTL

- Reads a block of 32-bit words from the program RAM and streams it out as bytes to the UART transmitter.
- It is the readback counterpart of the UART code-download path.
- Byte order matches the download path: little-endian, least significant byte first. A downloaded image dumps back byte-for-byte identical.
- Sits between the RAM read port and the UART TX byte interface. The host/debug controller triggers it with a start pulse.

---
 rtl/ram_uart_dump.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ram_uart_dump.sv
// Streams a block of 32-bit RAM words to a UART TX byte interface, LSB first.
// Optional DUMP_CHECKSUM_EN appends an 8-bit additive checksum byte after the data.
module ram_uart_dump #(
  parameter int COUNTW = 16
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              start,
  input  logic [31:0]       start_addr,
  input  logic [COUNTW-1:0] word_count,
  output logic [31:0]       rd_addr,
  input  logic [31:0]       rd_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND, FINISH} state_t;
`endif

  state_t            state;
  logic [COUNTW-1:0] remaining;
  logic [31:0]       word_reg;
  logic [1:0]        byte_idx;
  logic [1:0]        byte_idx_inc;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        csum_reg;
`endif

  assign byte_idx_inc = byte_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state     <= IDLE;
      remaining <= '0;
      word_reg  <= '0;
      byte_idx  <= '0;
      rd_addr   <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_addr   <= start_addr;
            remaining <= word_count;
            busy      <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            csum_reg  <= '0;
`endif
            if (word_count == '0) begin
`ifdef DUMP_CHECKSUM_EN
              // Empty dump still emits the (zero) checksum byte.
              tx_valid <= 1'b1;
              tx_data  <= 8'h00;
              state    <= CSUM;
`else
              state    <= FINISH;
`endif
            end else begin
              state <= FETCH;
            end
          end
        end

        FETCH: begin
          word_reg <= rd_data;
          tx_data  <= rd_data[7:0];
          tx_valid <= 1'b1;
          byte_idx <= 2'd0;
          state    <= SEND;
        end

        SEND: begin
          if (tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
            csum_reg <= csum_reg + tx_data;
`endif
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx_inc;
              tx_data  <= word_reg[{byte_idx_inc, 3'b000} +: 8];
            end else begin
              remaining <= remaining - COUNTW'(1);
              rd_addr   <= rd_addr + 32'd1;
              if (remaining == COUNTW'(1)) begin
`ifdef DUMP_CHECKSUM_EN
                // Fold in the final data byte being transferred this cycle.
                tx_data <= csum_reg + tx_data;
                state   <= CSUM;
`else
                tx_valid <= 1'b0;
                state    <= FINISH;
`endif
              end else begin
                tx_valid <= 1'b0;
                state    <= FETCH;
              end
            end
          end
        end

`ifdef DUMP_CHECKSUM_EN
        CSUM: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= FINISH;
          end
        end
`endif

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
